fetch_scheduler: RTL and testbench
==================================

FETCH_SCHEDULER -- requirements
Module: fetch_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- channel_num, 4, number of column FIFOs sharing the value ROM
- channel_num_log, 2, width of a channel index
- addr_bits, 13, ROM address width
- fifo_depth, 16, words per column FIFO
- matrix_num, 3, matrices fetched per run
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse beginning a run; ignored unless in IDLE
- base_addr  in  addr_bits*channel_num  per-channel first ROM address; sampled on start
- len  in  addr_bits*channel_num  per-channel words per matrix; sampled on start
- fifo_read  in  channel_num  pop strobes of the column FIFOs (credit return)
- rom_en  out  1  ROM read issued this cycle
- rom_addr  out  addr_bits  ROM address, valid while rom_en is high
- wr_en  out  channel_num  one-hot FIFO write strobe, aligned with ROM douta
- current_matrix  out  2  matrix being fetched (0..matrix_num-1)
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the run completes

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-004 IDLE -> FETCH on start; base_addr and len latched; per-channel remaining count loaded with len; current_matrix = 0.
REQ-005 A channel SHALL be eligible in FETCH when remaining > 0 and credit > 0.
REQ-006 Exactly one eligible channel SHALL be granted per cycle, round-robin: search starts at last granted + 1, modulo channel_num.
REQ-007 A grant SHALL, at the next edge:
- set rom_en = 1 and rom_addr = that channel's address
- increment the channel's address
- decrement its remaining count and its credit
REQ-008 With no eligible channel, rom_en SHALL be 0 in the next cycle.
REQ-009 wr_en[i] SHALL be rom_en delayed by one register for the granted channel i; the ROM has a registered output, so read latency is one cycle.
REQ-010 Credit per channel:
- width clog2(fifo_depth+1); reset and start value fifo_depth
- +1 on fifo_read[i]; grant and fifo_read in the same cycle leave it unchanged
- saturates at fifo_depth
- guarantees no FIFO overflow in spite of the ROM latency
REQ-011 A channel with len = 0 SHALL be finished for every matrix immediately.
REQ-012 When every remaining count is 0 and current_matrix < matrix_num-1, the block SHALL:
- increment current_matrix
- reload remaining counts from len
- continue each channel's address from its current value, with no gap
- stay in FETCH
REQ-013 When every remaining count is 0 on the last matrix, FETCH SHALL go to DRAIN.
REQ-014 DRAIN SHALL last until the final wr_en has been issued, then go to DONE.
REQ-015 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-016 Address arithmetic SHALL be modulo 2^addr_bits; wrap-around is not an error.

Reset
REQ-017 On rst the block SHALL immediately enter IDLE with:
- rom_en = 0, wr_en = 0, done = 0, busy = 0, current_matrix = 0, rom_addr = 0
- all credits = fifo_depth, remaining = 0, round-robin pointer = channel_num-1
REQ-018 Reset mid-run SHALL abandon any in-flight read, so no wr_en appears after reset; the column FIFOs share rst.

Structure
REQ-019 The shared parameter header SHALL hold channel_num, channel_num_log, addr_bits, fifo_depth, matrix_num and the FSM state encodings.
REQ-020 The round-robin picker SHALL be one sub-module, rr_arbiter: request vector and last-grant pointer in, one-hot grant and index out; purely combinational.

Verification
REQ-021 The bench SHALL cover these scenarios:
- channel_num = 4, len = 2 each, base = 0/100/200/300, no reads -> ROM address order 0, 100, 200, 300, 1, 101, 201, 301; wr_en one cycle after each rom_en; current_matrix 0 -> 1 -> 2; done after 24 writes.
- fifo_depth = 16, len[0] = 40, fifo_read never asserted -> exactly 16 grants for ch0, then rom_en stays 0; one fifo_read[0] -> exactly one more grant.
- len = 0/5/0/5 -> only ch1 and ch3 granted, alternately; each sees 15 addresses over 3 matrices.
- Same-cycle grant and fifo_read on ch2 with credit = 1 -> credit stays 1 and ch2 is granted again next cycle.
- base_addr[0] = 8190, len = 4 -> addresses 8190, 8191, 0, 1.
- rst asserted in FETCH with an outstanding read -> busy and wr_en low immediately; a new start replays from base_addr.

Source files
------------

// File: rtl/fetch_scheduler_pkg.sv
// Shared parameters and FSM encoding for the column-FIFO fetch scheduler.
package fetch_scheduler_pkg;

   localparam int fs_channel_num     = 4;
   localparam int fs_channel_num_log = 2;
   localparam int fs_addr_bits       = 13;
   localparam int fs_fifo_depth      = 16;
   localparam int fs_matrix_num      = 3;

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_fetch = 2'd1,
      st_drain = 2'd2,
      st_done  = 2'd3
   } state_t;

endpackage

// File: rtl/fetch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the search begins one past the last grant.
module rr_arbiter #(
   parameter int n     = 4,
   parameter int n_log = 2
) (
   input  logic [n-1:0]     req,
   input  logic [n_log-1:0] last,
   output logic [n-1:0]     grant,
   output logic [n_log-1:0] idx,
   output logic             valid
);

   int               j;
   logic [n_log-1:0] jj;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      jj    = '0;
      for (int off = 1; off <= n; off++) begin
         j = int'(last) + off;
         if (j >= n) j = j - n;
         jj = j[n_log-1:0];
         if (!valid && req[jj]) begin
            valid     = 1'b1;
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end

endmodule

// File: rtl/fetch_scheduler.sv
// Credit-gated round-robin ROM fetch for several column FIFOs, repeated over
// matrix_num matrices; wr_en follows each read by the ROM's one-cycle latency.
module fetch_scheduler
   import fetch_scheduler_pkg::*;
#(
   parameter int channel_num     = fs_channel_num,
   parameter int channel_num_log = fs_channel_num_log,
   parameter int addr_bits       = fs_addr_bits,
   parameter int fifo_depth      = fs_fifo_depth,
   parameter int matrix_num      = fs_matrix_num
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [addr_bits*channel_num-1:0] base_addr,
   input  logic [addr_bits*channel_num-1:0] len,
   input  logic [channel_num-1:0]           fifo_read,
   output logic                             rom_en,
   output logic [addr_bits-1:0]             rom_addr,
   output logic [channel_num-1:0]           wr_en,
   output logic [1:0]                       current_matrix,
   output logic                             busy,
   output logic                             done
);

   localparam int                          credit_bits = $clog2(fifo_depth + 1);
   localparam logic [credit_bits-1:0]      credit_full = credit_bits'(fifo_depth);
   localparam logic [credit_bits-1:0]      credit_one  = credit_bits'(1);
   localparam logic [addr_bits-1:0]        addr_one    = addr_bits'(1);
   localparam logic [1:0]                  last_matrix = 2'(matrix_num - 1);
   localparam logic [channel_num_log-1:0]  last_reset  = channel_num_log'(channel_num - 1);

   state_t state, state_next;

   logic [addr_bits-1:0]       addr_q   [channel_num];
   logic [addr_bits-1:0]       len_q    [channel_num];
   logic [addr_bits-1:0]       rem_q    [channel_num];
   logic [credit_bits-1:0]     credit_q [channel_num];

   logic [channel_num-1:0]     req, gnt;
   logic [channel_num_log-1:0] gnt_idx, last_q, rom_ch_q;
   logic                       gnt_valid, all_zero;
   logic                       rom_en_q;
   logic [addr_bits-1:0]       rom_addr_q;
   logic [channel_num-1:0]     wr_en_q;
   logic [1:0]                 matrix_q;
   logic                       launch, advance;

   assign launch  = (state == st_idle) && start;
   assign advance = (state == st_fetch) && all_zero && (matrix_q != last_matrix);

   // A channel with nothing left (including len = 0) never requests.
   always_comb begin
      req      = '0;
      all_zero = 1'b1;
      for (int i = 0; i < channel_num; i++) begin
         if (rem_q[i] != '0) all_zero = 1'b0;
         req[i] = (state == st_fetch) && (rem_q[i] != '0) && (credit_q[i] != '0);
      end
   end

   rr_arbiter #(
      .n     (channel_num),
      .n_log (channel_num_log)
   ) u_rr_arbiter (
      .req   (req),
      .last  (last_q),
      .grant (gnt),
      .idx   (gnt_idx),
      .valid (gnt_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= st_idle;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         st_idle:  if (start) state_next = st_fetch;
         st_fetch: if (all_zero && (matrix_q == last_matrix)) state_next = st_drain;
         st_drain: if (!rom_en_q) state_next = st_done;
         st_done:  state_next = st_idle;
         default:  state_next = st_idle;
      endcase
   end

   // Per-channel address and remaining count; addresses carry across matrices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < channel_num; i++) begin
            addr_q[i] <= '0;
            len_q[i]  <= '0;
            rem_q[i]  <= '0;
         end
         matrix_q <= '0;
      end else begin
         for (int i = 0; i < channel_num; i++) begin
            if (launch) begin
               addr_q[i] <= base_addr[i*addr_bits +: addr_bits];
               len_q[i]  <= len[i*addr_bits +: addr_bits];
               rem_q[i]  <= len[i*addr_bits +: addr_bits];
            end else if (gnt[i]) begin
               addr_q[i] <= addr_q[i] + addr_one;
               rem_q[i]  <= rem_q[i] - addr_one;
            end else if (advance) begin
               rem_q[i]  <= len_q[i];
            end
         end
         if (launch)       matrix_q <= '0;
         else if (advance) matrix_q <= matrix_q + 2'd1;
      end
   end

   // Credits mirror free FIFO slots, counting reads still in flight through the ROM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < channel_num; i++) credit_q[i] <= credit_full;
      end else begin
         for (int i = 0; i < channel_num; i++) begin
            case ({gnt[i], fifo_read[i]})
               2'b10:   credit_q[i] <= credit_q[i] - credit_one;
               2'b01:   if (credit_q[i] != credit_full) credit_q[i] <= credit_q[i] + credit_one;
               default: credit_q[i] <= credit_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         rom_ch_q   <= '0;
         last_q     <= last_reset;
         wr_en_q    <= '0;
      end else begin
         rom_en_q <= gnt_valid;
         wr_en_q  <= rom_en_q ? (channel_num'(1) << rom_ch_q) : '0;
         if (gnt_valid) begin
            rom_addr_q <= addr_q[gnt_idx];
            rom_ch_q   <= gnt_idx;
            last_q     <= gnt_idx;
         end
      end
   end

   assign rom_en         = rom_en_q;
   assign rom_addr       = rom_addr_q;
   assign wr_en          = wr_en_q;
   assign current_matrix = matrix_q;
   assign busy           = (state != st_idle);
   assign done           = (state == st_done);

endmodule

// File: tb/tb_fetch_scheduler.sv
// Bench for fetch_scheduler: cycle-level reference model plus literal pins.
module tb_fetch_scheduler;

   localparam int n     = 4;
   localparam int ab    = 13;
   localparam int depth = 16;
   localparam int mats  = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [ab*n-1:0] base_addr;
   logic [ab*n-1:0] len;
   logic [n-1:0]    fifo_read;
   logic            rom_en;
   logic [ab-1:0]   rom_addr;
   logic [n-1:0]    wr_en;
   logic [1:0]      current_matrix;
   logic            busy;
   logic            done;

   fetch_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_addr      (base_addr),
      .len            (len),
      .fifo_read      (fifo_read),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .wr_en          (wr_en),
      .current_matrix (current_matrix),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_phase;                // 0 idle, 1 fetch, 2 drain, 3 done
   int m_rem [n];
   int m_cred[n];
   int m_addr[n];
   int m_len [n];
   int m_last, m_mat, m_rom_en, m_rom_addr, m_rom_ch, m_wr;

   int t_base[n];
   int t_len [n];
   int rd_mode;                // 0 none, 1 random, 2 single ch2 same-cycle read, 3 one-shot ch0
   bit sc4_fired;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ab-1:0] addr_log[$];
   logic [ab-1:0] exp_q[$];
   int            wr_log[$];
   int            wr_cnt[n];
   int            done_cnt, max_mat, cur_run, max_run;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      for (int i = 0; i < n; i++) begin
         m_rem[i] = 0; m_cred[i] = depth; m_addr[i] = 0; m_len[i] = 0;
      end
      m_last = n - 1; m_mat = 0; m_rom_en = 0; m_rom_addr = 0; m_rom_ch = 0; m_wr = 0;
   endtask

   task automatic model_step();
      int g, nw, prev_rom_en, j;
      bit all0;
      nw = m_rom_en ? (1 << m_rom_ch) : 0;
      prev_rom_en = m_rom_en;
      all0 = 1'b1;
      for (int i = 0; i < n; i++) if (m_rem[i] != 0) all0 = 1'b0;
      g = -1;
      if (m_phase == 1) begin
         for (int k = 1; k <= n; k++) begin
            j = (m_last + k) % n;
            if (g < 0 && m_rem[j] > 0 && m_cred[j] > 0) g = j;
         end
      end
      for (int i = 0; i < n; i++) begin
         if (i == g && !fifo_read[i]) m_cred[i]--;
         else if (i != g && fifo_read[i] && m_cred[i] < depth) m_cred[i]++;
      end
      if (g >= 0) begin
         m_rom_addr = m_addr[g];
         m_rom_ch   = g;
         m_addr[g]  = (m_addr[g] + 1) % (1 << ab);
         m_rem[g]--;
         m_last     = g;
      end
      m_rom_en = (g >= 0);
      m_wr     = nw;
      case (m_phase)
         0: if (start) begin
               m_phase = 1; m_mat = 0;
               for (int i = 0; i < n; i++) begin
                  m_addr[i] = t_base[i]; m_len[i] = t_len[i]; m_rem[i] = t_len[i];
               end
            end
         1: if (all0) begin
               if (m_mat < mats - 1) begin
                  m_mat++;
                  for (int i = 0; i < n; i++) m_rem[i] = m_len[i];
               end else m_phase = 2;
            end
         2: if (!prev_rom_en) m_phase = 3;
         default: m_phase = 0;
      endcase
   endtask

   // ---------------- compare process ----------------
   task automatic check_outputs();
      chk("rom_en", rom_en, m_rom_en);
      if (m_rom_en) chk("rom_addr", rom_addr, m_rom_addr);
      chk("wr_en", wr_en, m_wr);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("current_matrix", current_matrix, m_mat);
   endtask

   task automatic clear_logs();
      addr_log.delete(); exp_q.delete(); wr_log.delete();
      for (int i = 0; i < n; i++) wr_cnt[i] = 0;
      done_cnt = 0; max_mat = 0; cur_run = 0; max_run = 0;
   endtask

   task automatic tick();
      case (rd_mode)
         1: fifo_read = 4'($urandom_range(0, 15));
         2: begin
               fifo_read = '0;
               if (m_phase == 1 && m_cred[2] == 1 && !sc4_fired) begin
                  fifo_read[2] = 1'b1; sc4_fired = 1'b1;
               end
            end
         3: begin fifo_read = 4'b0001; rd_mode = 0; end
         default: fifo_read = '0;
      endcase
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      if (rom_en) begin addr_log.push_back(rom_addr); cur_run++; end
      else cur_run = 0;
      if (cur_run > max_run) max_run = cur_run;
      for (int i = 0; i < n; i++) if (wr_en[i]) begin wr_cnt[i]++; wr_log.push_back(i); end
      if (done) done_cnt++;
      if (int'(current_matrix) > max_mat) max_mat = int'(current_matrix);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; fifo_read = '0; rd_mode = 0;
      model_reset();
      #1;
      chk("rst_rom_en", rom_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_matrix", current_matrix, 0);
      chk("rst_rom_addr", rom_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic start_run();
      for (int i = 0; i < n; i++) begin
         base_addr[i*ab +: ab] = ab'(t_base[i]);
         len[i*ab +: ab]       = ab'(t_len[i]);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_idle(input int max_cycles);
      int c;
      c = 0;
      while (m_phase != 0 && c < max_cycles) begin tick(); c++; end
      if (m_phase != 0) chk("run_timeout", 1, 0);
   endtask

   task automatic set_cfg(input int b0, b1, b2, b3, l0, l1, l2, l3);
      t_base[0] = b0; t_base[1] = b1; t_base[2] = b2; t_base[3] = b3;
      t_len[0]  = l0; t_len[1]  = l1; t_len[2]  = l2; t_len[3]  = l3;
   endtask

   initial begin
      int viol;
      base_addr = '0; len = '0; fifo_read = '0; start = 1'b0; rst = 1'b1;
      rd_mode = 0; sc4_fired = 1'b0;
      do_reset();

      // 1: four channels, two words each, three matrices
      set_cfg(0, 100, 200, 300, 2, 2, 2, 2);
      start_run();
      run_until_idle(400);
      for (int m = 0; m < mats; m++)
         for (int k = 0; k < 2; k++)
            for (int c = 0; c < n; c++) exp_q.push_back(ab'(100 * c + 2 * m + k));
      chk("s1_addr_count", addr_log.size(), 24);
      while (exp_q.size() > 0 && addr_log.size() > 0)
         chk("s1_addr_order", addr_log.pop_front(), exp_q.pop_front());
      chk("s1_writes", wr_log.size(), 24);
      chk("s1_max_matrix", max_mat, 2);
      chk("s1_done_pulses", done_cnt, 1);

      // 2: credit exhaustion on ch0, then a single credit return
      do_reset();
      set_cfg(0, 0, 0, 0, 40, 0, 0, 0);
      start_run();
      repeat (60) tick();
      chk("s2_grants_no_reads", addr_log.size(), 16);
      rd_mode = 3;
      repeat (10) tick();
      chk("s2_grants_one_read", addr_log.size(), 17);

      // 3: only ch1 and ch3 have work
      do_reset();
      set_cfg(int'($urandom_range(0, 8191)), 500, int'($urandom_range(0, 8191)), 7000, 0, 5, 0, 5);
      start_run();
      run_until_idle(400);
      chk("s3_ch0", wr_cnt[0], 0);
      chk("s3_ch1", wr_cnt[1], 15);
      chk("s3_ch2", wr_cnt[2], 0);
      chk("s3_ch3", wr_cnt[3], 15);
      viol = 0;
      for (int k = 1; k < wr_log.size(); k++) if (wr_log[k] == wr_log[k-1]) viol++;
      chk("s3_alternation", viol, 0);

      // 4: same-cycle grant and credit return on ch2 at credit 1
      do_reset();
      set_cfg(0, 0, 40, 0, 0, 0, 40, 0);
      rd_mode = 2; sc4_fired = 1'b0;
      start_run();
      repeat (40) tick();
      chk("s4_read_seen", sc4_fired, 1);
      chk("s4_grants", addr_log.size(), 17);
      chk("s4_back_to_back", max_run, 17);

      // 5: address wrap-around
      do_reset();
      set_cfg(8190, 0, 0, 0, 4, 0, 0, 0);
      start_run();
      run_until_idle(200);
      exp_q.push_back(13'd8190); exp_q.push_back(13'd8191); exp_q.push_back(13'd0);
      exp_q.push_back(13'd1);    exp_q.push_back(13'd2);    exp_q.push_back(13'd3);
      chk("s5_addr_count", addr_log.size(), 12);
      while (exp_q.size() > 0 && addr_log.size() > 0)
         chk("s5_wrap_addr", addr_log.pop_front(), exp_q.pop_front());

      // 6: reset with a read in flight, then replay
      do_reset();
      set_cfg(int'($urandom_range(0, 8191)), 10, 20, 30, 3, 3, 3, 3);
      start_run();
      for (int c = 0; c < 8 && !m_rom_en; c++) tick();
      chk("s6_read_in_flight", rom_en, 1);
      do_reset();
      start_run();
      run_until_idle(400);
      chk("s6_replay_first", (addr_log.size() > 0) ? 32'(addr_log[0]) : 32'hffff_ffff, t_base[0]);
      chk("s6_replay_writes", wr_log.size(), 36);

      // random runs with random credit returns
      for (int r = 0; r < 8; r++) begin
         do_reset();
         for (int i = 0; i < n; i++) begin
            t_base[i] = int'($urandom_range(0, 8191));
            t_len[i]  = int'($urandom_range(0, 12));
         end
         rd_mode = 1;
         start_run();
         run_until_idle(4000);
         chk("rand_total_writes", wr_log.size(), 3 * (t_len[0] + t_len[1] + t_len[2] + t_len[3]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
